// File: rtl/mem_stage.sv
// mem_stage: load/store bus stage with req/ack handshake, lane steering and load formatting
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_f3,
  input  logic            i_rd_en,
  input  logic            i_wr_en,
  output logic            o_DM_req,
  output logic            o_DM_wr,
  output logic [XLEN-1:0] o_DM_addr,
  output logic [XLEN-1:0] o_DM_wdata,
  output logic [3:0]      o_DM_byte_en,
  input  logic            i_DM_ack,
  input  logic [XLEN-1:0] i_DM_rdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_stall,
  output logic            o_misaligned
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic access, is_byte, is_half, mis, go;
  logic [3:0] be;
  logic [XLEN-1:0] wd, fmt;
  logic [1:0] lo_q;
  logic byte_q, half_q, uns_q, load_q;
  logic [7:0] lb;
  logic [15:0] lh;
  // Unsigned encodings only exist for loads; anything unrecognised falls through to word.
  always_comb begin
    access = i_rd_en | i_wr_en;
    is_byte = i_f3 == 3'b000 || (i_rd_en && i_f3 == 3'b100);
    is_half = i_f3 == 3'b001 || (i_rd_en && i_f3 == 3'b101);
    mis = is_half ? i_addr[0] : (!is_byte && i_addr[1:0] != 2'b00);
    go = state == IDLE && access && !mis;
    be = is_byte ? 4'b0001 << i_addr[1:0] : is_half ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
    wd = is_byte ? {4{i_wdata[7:0]}} : is_half ? {2{i_wdata[15:0]}} : i_wdata;
    lb = i_DM_rdata[{lo_q, 3'b000} +: 8];
    lh = lo_q[1] ? i_DM_rdata[31:16] : i_DM_rdata[15:0];
    fmt = byte_q ? {{24{~uns_q & lb[7]}}, lb} : half_q ? {{16{~uns_q & lh[15]}}, lh} : i_DM_rdata;
    o_stall = go || state == BUSY;
    o_misaligned = state == IDLE && access && mis;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      o_DM_req <= 1'b0;
      o_DM_wr <= 1'b0;
      o_DM_addr <= '0;
      o_DM_wdata <= '0;
      o_DM_byte_en <= 4'b0000;
      o_rdata <= '0;
      lo_q <= 2'b00;
      byte_q <= 1'b0;
      half_q <= 1'b0;
      uns_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= BUSY;
          o_DM_req <= 1'b1;
          o_DM_wr <= ~i_rd_en;
          o_DM_addr <= {i_addr[XLEN-1:2], 2'b00};
          o_DM_wdata <= wd;
          o_DM_byte_en <= be;
          lo_q <= i_addr[1:0];
          byte_q <= is_byte;
          half_q <= is_half;
          uns_q <= i_f3[2];
          load_q <= i_rd_en;
        end
        BUSY: if (i_DM_ack) begin
          state <= DONE;
          o_DM_req <= 1'b0;
          o_DM_wr <= 1'b0;
          o_DM_byte_en <= 4'b0000;
          if (load_q) o_rdata <= fmt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
